// File: rtl/alu_req_scheduler.sv
// Two-requester round-robin front end for a shared combinational ALU: registers the
// granted operands, waits a settle time, captures the ALU output and returns it tagged.
module alu_req_scheduler #(
    parameter int OP_W   = 3,
    parameter int ARG_W  = 4,
    parameter int RES_W  = 8,
    parameter int STAT_W = 4,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [1:0]           i_req_valid,
    output logic [1:0]           o_req_ready,
    input  logic [2*OP_W-1:0]    i_req_op,
    input  logic [2*ARG_W-1:0]   i_req_arg_A,
    input  logic [2*ARG_W-1:0]   i_req_arg_B,
    output logic [OP_W-1:0]      o_alu_op,
    output logic [ARG_W-1:0]     o_alu_arg_A,
    output logic [ARG_W-1:0]     o_alu_arg_B,
    input  logic [RES_W-1:0]     i_alu_result,
    input  logic [STAT_W-1:0]    i_alu_status,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic                 o_rsp_tag,
    output logic [RES_W-1:0]     o_rsp_result,
    output logic [STAT_W-1:0]    o_rsp_status,
    output logic                 o_busy,
    output logic [CNT_W-1:0]     o_op_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

    state_t             state;
    state_t             state_nxt;
    logic               last_grant;
    logic               grant;
    logic               accept;
    logic               tag;
    logic [3:0]         settle_cnt;
    logic [OP_W-1:0]    sel_op;
    logic [ARG_W-1:0]   sel_arg_a;
    logic [ARG_W-1:0]   sel_arg_b;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v)
            return v;
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Arbitration depends only on request valids and registered state, never on ALU or response inputs.
    always_comb begin
        grant       = 1'b0;
        o_req_ready = 2'b00;
        if (i_req_valid == 2'b10)
            grant = 1'b1;
        else if (i_req_valid == 2'b11)
            grant = ~last_grant;
        if (state == IDLE && i_req_valid != 2'b00)
            o_req_ready = grant ? 2'b10 : 2'b01;
    end

    assign accept    = |o_req_ready;
    assign sel_op    = grant ? i_req_op[2*OP_W-1:OP_W]      : i_req_op[OP_W-1:0];
    assign sel_arg_a = grant ? i_req_arg_A[2*ARG_W-1:ARG_W] : i_req_arg_A[ARG_W-1:0];
    assign sel_arg_b = grant ? i_req_arg_B[2*ARG_W-1:ARG_W] : i_req_arg_B[ARG_W-1:0];
    assign o_busy    = (state != IDLE);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   if (settle_cnt == 4'd0) state_nxt = CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP:    if (o_rsp_valid && i_rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            last_grant   <= 1'b1;
            tag          <= 1'b0;
            settle_cnt   <= 4'd0;
            o_alu_op     <= '0;
            o_alu_arg_A  <= '0;
            o_alu_arg_B  <= '0;
            o_rsp_valid  <= 1'b0;
            o_rsp_tag    <= 1'b0;
            o_rsp_result <= '0;
            o_rsp_status <= '0;
            o_op_count   <= '0;
        end else begin
            case (state)
                // Issue: operands are only ever loaded on the accept edge.
                IDLE: begin
                    if (accept) begin
                        o_alu_op    <= sel_op;
                        o_alu_arg_A <= sel_arg_a;
                        o_alu_arg_B <= sel_arg_b;
                        tag         <= grant;
                        last_grant  <= grant;
                        settle_cnt  <= SETTLE_LD;
                    end
                end
                ISSUE: begin
                    if (settle_cnt != 4'd0)
                        settle_cnt <= settle_cnt - 4'd1;
                end
                // Capture: ALU output has settled against stable operands.
                CAPTURE: begin
                    o_rsp_result <= i_alu_result;
                    o_rsp_status <= i_alu_status;
                    o_rsp_tag    <= tag;
                    o_rsp_valid  <= 1'b1;
                end
                // Response: everything held until the consumer takes it.
                RESP: begin
                    if (o_rsp_valid && i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_op_count  <= sat_inc(o_op_count);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler: two instances (SETTLE=1/CNT_W=16 and SETTLE=4/CNT_W=2)
// share stimulus; a transaction-level model predicts grants, timing and responses.
`timescale 1ns/1ps
module tb_alu_req_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  req_valid;
    logic [5:0]  req_op;
    logic [7:0]  req_a;
    logic [7:0]  req_b;
    logic        rsp_ready;

    logic [1:0]  ready_a,     ready_b;
    logic [2:0]  alu_op_a,    alu_op_b;
    logic [3:0]  alu_a_a,     alu_a_b;
    logic [3:0]  alu_b_a,     alu_b_b;
    logic [7:0]  alu_res_a,   alu_res_b;
    logic [3:0]  alu_stat_a,  alu_stat_b;
    logic        rsp_valid_a, rsp_valid_b;
    logic        rsp_tag_a,   rsp_tag_b;
    logic [7:0]  rsp_res_a,   rsp_res_b;
    logic [3:0]  rsp_stat_a,  rsp_stat_b;
    logic        busy_a,      busy_b;
    logic [15:0] count_a;
    logic [1:0]  count_b;

    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [7:0] x;
        logic [7:0] y;
        x = {4'd0, a};
        y = {4'd0, b};
        case (op)
            3'd0:    return (x + y) >> 1;
            3'd1:    return x + y;
            3'd2:    return x - y;
            3'd3:    return x * y;
            3'd4:    return x & y;
            3'd5:    return x | y;
            3'd6:    return x ^ y;
            default: return {4'd0, ~a};
        endcase
    endfunction

    function automatic logic [3:0] stat_fn(input logic [2:0] op, input logic [7:0] r);
        return {r == 8'd0, r[7], ^r, op == 3'd7};
    endfunction

    assign alu_res_a  = alu_fn(alu_op_a, alu_a_a, alu_b_a);
    assign alu_stat_a = stat_fn(alu_op_a, alu_res_a);
    assign alu_res_b  = alu_fn(alu_op_b, alu_a_b, alu_b_b);
    assign alu_stat_b = stat_fn(alu_op_b, alu_res_b);

    alu_req_scheduler #(.OP_W(3), .ARG_W(4), .RES_W(8), .STAT_W(4), .SETTLE(1), .CNT_W(16)) dut_a (
        .i_clk(clk), .i_reset(rst_n),
        .i_req_valid(req_valid), .o_req_ready(ready_a),
        .i_req_op(req_op), .i_req_arg_A(req_a), .i_req_arg_B(req_b),
        .o_alu_op(alu_op_a), .o_alu_arg_A(alu_a_a), .o_alu_arg_B(alu_b_a),
        .i_alu_result(alu_res_a), .i_alu_status(alu_stat_a),
        .o_rsp_valid(rsp_valid_a), .i_rsp_ready(rsp_ready), .o_rsp_tag(rsp_tag_a),
        .o_rsp_result(rsp_res_a), .o_rsp_status(rsp_stat_a),
        .o_busy(busy_a), .o_op_count(count_a)
    );

    alu_req_scheduler #(.OP_W(3), .ARG_W(4), .RES_W(8), .STAT_W(4), .SETTLE(4), .CNT_W(2)) dut_b (
        .i_clk(clk), .i_reset(rst_n),
        .i_req_valid(req_valid), .o_req_ready(ready_b),
        .i_req_op(req_op), .i_req_arg_A(req_a), .i_req_arg_B(req_b),
        .o_alu_op(alu_op_b), .o_alu_arg_A(alu_a_b), .o_alu_arg_B(alu_b_b),
        .i_alu_result(alu_res_b), .i_alu_status(alu_stat_b),
        .o_rsp_valid(rsp_valid_b), .i_rsp_ready(rsp_ready), .o_rsp_tag(rsp_tag_b),
        .o_rsp_result(rsp_res_b), .o_rsp_status(rsp_stat_b),
        .o_busy(busy_b), .o_op_count(count_b)
    );

    // View of whichever instance the current scenario targets.
    logic        sel;
    logic [1:0]  m_ready;
    logic [10:0] m_alu;
    logic        m_rsp_valid, m_tag, m_busy;
    logic [7:0]  m_res;
    logic [3:0]  m_stat;
    logic [15:0] m_count;
    assign m_ready     = sel ? ready_b : ready_a;
    assign m_alu       = sel ? {alu_op_b, alu_a_b, alu_b_b} : {alu_op_a, alu_a_a, alu_b_a};
    assign m_rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
    assign m_tag       = sel ? rsp_tag_b : rsp_tag_a;
    assign m_res       = sel ? rsp_res_b : rsp_res_a;
    assign m_stat      = sel ? rsp_stat_b : rsp_stat_a;
    assign m_busy      = sel ? busy_b : busy_a;
    assign m_count     = sel ? {14'd0, count_b} : count_a;

    int          checks = 0;
    int          failures = 0;
    logic        m_last;
    int          m_cnt;
    logic [10:0] m_alu_hold;
    int          settle;
    int          cnt_max;
    int          g_log[$];
    int          cnt_log[$];

    task automatic model_reset();
        m_last     = 1'b1;
        m_cnt      = 0;
        m_alu_hold = '0;
    endtask

    task automatic select_dut(input logic s);
        sel     = s;
        settle  = s ? 4 : 1;
        cnt_max = s ? 3 : 65535;
    endtask

    task automatic do_reset(input logic [1:0] v, input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        rst_n = 1'b0;
        req_valid = v; req_op = op; req_a = a; req_b = b; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    // mode 0: both requesters always valid, consumer always ready
    // mode 1: random request arrival and random consumer backpressure
    // mode 2: only requester 0, consumer always ready
    task automatic run_traffic(input int n, input int mode);
        logic       inflight, cur_tag, just_hs, drop, drop_r, g, exp_rv;
        logic [7:0] cur_res;
        logic [3:0] cur_stat;
        logic [1:0] exp_ready;
        logic [2:0] op_g;
        logic [3:0] a_g, b_g;
        int         age, done, cyc, last_acc, n_acc;
        inflight = 0; cur_tag = 0; just_hs = 0; drop = 0; drop_r = 0; g = 0;
        cur_res = 0; cur_stat = 0; age = 0; done = 0; cyc = 0; last_acc = 0; n_acc = 0;
        g_log.delete();
        cnt_log.delete();
        forever begin
            @(negedge clk);
            cyc++;
            exp_rv = inflight && (age >= settle + 1);
            checks++;
            if (m_busy !== inflight) begin
                failures++; $display("FAIL busy cyc=%0d got=%b want=%b", cyc, m_busy, inflight);
            end
            checks++;
            if (m_rsp_valid !== exp_rv) begin
                failures++; $display("FAIL rsp_valid cyc=%0d got=%b want=%b", cyc, m_rsp_valid, exp_rv);
            end
            if (exp_rv) begin
                checks++;
                if ({m_tag, m_res, m_stat} !== {cur_tag, cur_res, cur_stat}) begin
                    failures++;
                    $display("FAIL rsp_data got tag=%b res=%h st=%b want tag=%b res=%h st=%b",
                             m_tag, m_res, m_stat, cur_tag, cur_res, cur_stat);
                end
            end
            checks++;
            if (m_alu !== m_alu_hold) begin
                failures++; $display("FAIL alu_operands cyc=%0d got=%h want=%h", cyc, m_alu, m_alu_hold);
            end
            checks++;
            if (m_count !== m_cnt[15:0]) begin
                failures++; $display("FAIL op_count cyc=%0d got=%0d want=%0d", cyc, m_count, m_cnt);
            end
            if (just_hs) cnt_log.push_back(int'(m_count));
            just_hs = 0;
            if (done == n) break;
            if (cyc > 40 * n + 40) begin
                failures++; $display("FAIL traffic_timeout done=%0d want=%0d", done, n);
                break;
            end
            if (drop) begin
                req_valid[drop_r] = 1'b0;
                drop = 0;
            end
            for (int r = 0; r < 2; r++) begin
                if (!req_valid[r] && (mode == 0 || (mode == 2 && r == 0) ||
                                      (mode == 1 && $urandom_range(0, 1) == 1))) begin
                    req_valid[r]     = 1'b1;
                    req_op[r*3 +: 3] = 3'($urandom_range(0, 7));
                    req_a[r*4 +: 4]  = 4'($urandom_range(0, 15));
                    req_b[r*4 +: 4]  = 4'($urandom_range(0, 15));
                end
            end
            rsp_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            exp_ready = 2'b00;
            if (!inflight && req_valid != 2'b00) begin
                g = (req_valid == 2'b11) ? ~m_last : req_valid[1];
                exp_ready[g] = 1'b1;
            end
            checks++;
            if (m_ready !== exp_ready) begin
                failures++; $display("FAIL req_ready cyc=%0d got=%b want=%b", cyc, m_ready, exp_ready);
            end
            if (exp_ready != 2'b00) begin
                op_g = g ? req_op[5:3] : req_op[2:0];
                a_g  = g ? req_a[7:4]  : req_a[3:0];
                b_g  = g ? req_b[7:4]  : req_b[3:0];
                inflight = 1; age = 0; cur_tag = g;
                cur_res  = alu_fn(op_g, a_g, b_g);
                cur_stat = stat_fn(op_g, cur_res);
                m_alu_hold = {op_g, a_g, b_g};
                m_last = g;
                g_log.push_back(int'(g));
                if (mode != 1 && n_acc > 0) begin
                    checks++;
                    if (cyc - last_acc != settle + 3) begin
                        failures++; $display("FAIL initiation_interval got=%0d want=%0d", cyc - last_acc, settle + 3);
                    end
                end
                last_acc = cyc; n_acc++;
                drop = 1; drop_r = g;
            end else if (inflight) begin
                if (exp_rv && rsp_ready) begin
                    inflight = 0; done++; just_hs = 1;
                    if (m_cnt != cnt_max) m_cnt++;
                end else begin
                    age++;
                end
            end
        end
        req_valid = 2'b00;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        select_dut(1'b0);
        rst_n = 1'b0; req_valid = 2'b00; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({alu_op_a, alu_a_a, alu_b_a} !== 11'd0) begin
            failures++; $display("FAIL reset_alu got=%h want=0", {alu_op_a, alu_a_a, alu_b_a});
        end
        checks++;
        if ({rsp_valid_a, rsp_tag_a, rsp_res_a, rsp_stat_a} !== 14'd0) begin
            failures++; $display("FAIL reset_rsp got=%h want=0", {rsp_valid_a, rsp_tag_a, rsp_res_a, rsp_stat_a});
        end
        checks++;
        if ({busy_a, count_a, busy_b, count_b} !== 20'd0) begin
            failures++; $display("FAIL reset_ctrl got=%h want=0", {busy_a, count_a, busy_b, count_b});
        end
    endtask

    task automatic test_single_request();
        int lat;
        select_dut(1'b0);
        do_reset(2'b00, 6'd0, 8'd0, 8'd0);
        @(negedge clk);
        req_valid = 2'b01; req_op = 6'd0; req_a = 8'h09; req_b = 8'h02;
        #1;
        checks++;
        if (ready_a !== 2'b01) begin failures++; $display("FAIL single_ready got=%b want=01", ready_a); end
        @(negedge clk);
        req_valid = 2'b00;
        checks++;
        if ({alu_op_a, alu_a_a, alu_b_a} !== {3'd0, 4'd9, 4'd2} || rsp_valid_a !== 1'b0) begin
            failures++; $display("FAIL single_issue got alu=%h v=%b want alu=%h v=0",
                                 {alu_op_a, alu_a_a, alu_b_a}, rsp_valid_a, {3'd0, 4'd9, 4'd2});
        end
        lat = 0;
        while (!rsp_valid_a && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 2) begin failures++; $display("FAIL single_latency got=%0d want=2", lat); end
        checks++;
        if ({rsp_tag_a, rsp_res_a, rsp_stat_a, count_a} !== {1'b0, 8'h05, 4'b0000, 16'd0}) begin
            failures++; $display("FAIL single_rsp got tag=%b res=%h st=%b cnt=%0d want tag=0 res=05 st=0000 cnt=0",
                                 rsp_tag_a, rsp_res_a, rsp_stat_a, count_a);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid_a, busy_a, count_a} !== {1'b0, 1'b0, 16'd1}) begin
            failures++; $display("FAIL single_done got v=%b busy=%b cnt=%0d want v=0 busy=0 cnt=1",
                                 rsp_valid_a, busy_a, count_a);
        end
    endtask

    task automatic test_simultaneous();
        select_dut(1'b0);
        do_reset(2'b11, {3'd1, 3'd1}, {4'd7, 4'd3}, {4'd2, 4'd1});
        run_traffic(2, 0);
        checks++;
        if (g_log.size() != 2 || g_log[0] != 0 || g_log[1] != 1) begin
            failures++; $display("FAIL simultaneous_order got=%p want='{0,1}", g_log);
        end
    endtask

    task automatic test_contention();
        select_dut(1'b0);
        do_reset(2'b00, 6'd0, 8'd0, 8'd0);
        run_traffic(6, 0);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= g_log.size() || g_log[i] != i % 2) begin
                failures++; $display("FAIL contention_grant idx=%0d got=%p want alternating", i, g_log);
            end
        end
        checks++;
        if (count_a !== 16'd6) begin failures++; $display("FAIL contention_count got=%0d want=6", count_a); end
    endtask

    task automatic test_back_to_back();
        select_dut(1'b0);
        do_reset(2'b00, 6'd0, 8'd0, 8'd0);
        run_traffic(4, 2);
        checks++;
        if (g_log.size() != 4 || g_log.sum() != 0) begin
            failures++; $display("FAIL back_to_back_grants got=%p want all 0", g_log);
        end
    endtask

    task automatic test_backpressure();
        int wait_cyc;
        select_dut(1'b0);
        do_reset(2'b00, 6'd0, 8'd0, 8'd0);
        @(negedge clk);
        req_valid = 2'b10; req_op = {3'd3, 3'd0}; req_a = 8'hF0; req_b = 8'hF0;
        #1;
        checks++;
        if (ready_a !== 2'b10) begin failures++; $display("FAIL bp_ready1 got=%b want=10", ready_a); end
        @(negedge clk);
        req_valid = 2'b01; req_op[2:0] = 3'd2; req_a[3:0] = 4'd1; req_b[3:0] = 4'd4;
        wait_cyc = 0;
        while (!rsp_valid_a && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rsp_valid_a, rsp_tag_a, rsp_res_a, rsp_stat_a, ready_a, alu_op_a, alu_a_a, alu_b_a} !==
                {1'b1, 1'b1, 8'hE1, 4'b0100, 2'b00, 3'd3, 4'hF, 4'hF}) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got v=%b tag=%b res=%h st=%b rdy=%b alu=%h want v=1 tag=1 res=e1 st=0100 rdy=00 alu=%h",
                         i, rsp_valid_a, rsp_tag_a, rsp_res_a, rsp_stat_a, ready_a,
                         {alu_op_a, alu_a_a, alu_b_a}, {3'd3, 4'hF, 4'hF});
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid_a, count_a, ready_a} !== {1'b0, 16'd1, 2'b01}) begin
            failures++; $display("FAIL bp_release got v=%b cnt=%0d rdy=%b want v=0 cnt=1 rdy=01",
                                 rsp_valid_a, count_a, ready_a);
        end
        @(negedge clk);
        req_valid = 2'b00;
        checks++;
        if ({busy_a, alu_op_a, alu_a_a, alu_b_a} !== {1'b1, 3'd2, 4'd1, 4'd4}) begin
            failures++; $display("FAIL bp_next_issue got busy=%b alu=%h want busy=1 alu=%h",
                                 busy_a, {alu_op_a, alu_a_a, alu_b_a}, {3'd2, 4'd1, 4'd4});
        end
        wait_cyc = 0;
        while (!rsp_valid_a && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        checks++;
        if ({rsp_valid_a, rsp_tag_a, rsp_res_a} !== {1'b1, 1'b0, 8'hFD}) begin
            failures++; $display("FAIL bp_second_rsp got v=%b tag=%b res=%h want v=1 tag=0 res=fd",
                                 rsp_valid_a, rsp_tag_a, rsp_res_a);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        select_dut(1'b1);
        do_reset(2'b00, 6'd0, 8'd0, 8'd0);
        run_traffic(1, 2);
        @(negedge clk);
        req_valid = 2'b01; req_op[2:0] = 3'd1; req_a[3:0] = 4'd5; req_b[3:0] = 4'd6; rsp_ready = 1'b1;
        #1;
        checks++;
        if (ready_b !== 2'b01) begin failures++; $display("FAIL midop_ready got=%b want=01", ready_b); end
        @(negedge clk);
        checks++;
        if ({busy_b, alu_a_b, count_b} !== {1'b1, 4'd5, 2'd1}) begin
            failures++; $display("FAIL midop_issue got busy=%b a=%0d cnt=%0d want busy=1 a=5 cnt=1",
                                 busy_b, alu_a_b, count_b);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_b, alu_op_b, alu_a_b, alu_b_b, rsp_valid_b, rsp_tag_b, rsp_res_b, rsp_stat_b, count_b} !== 28'd0) begin
            failures++; $display("FAIL midop_async_reset got=%h want=0",
                                 {busy_b, alu_op_b, alu_a_b, alu_b_b, rsp_valid_b, rsp_tag_b, rsp_res_b, rsp_stat_b, count_b});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({busy_b, count_b, ready_b} !== {1'b0, 2'd0, 2'b01}) begin
            failures++; $display("FAIL midop_after_release got busy=%b cnt=%0d rdy=%b want busy=0 cnt=0 rdy=01",
                                 busy_b, count_b, ready_b);
        end
        run_traffic(1, 0);
        checks++;
        if (g_log.size() != 1 || g_log[0] != 0 || count_b !== 2'd1) begin
            failures++; $display("FAIL midop_represent got grants=%p cnt=%0d want '{0} cnt=1", g_log, count_b);
        end
    endtask

    task automatic test_saturation();
        int exp_sat[5] = '{1, 2, 3, 3, 3};
        select_dut(1'b1);
        do_reset(2'b00, 6'd0, 8'd0, 8'd0);
        run_traffic(5, 0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= cnt_log.size() || cnt_log[i] != exp_sat[i]) begin
                failures++; $display("FAIL saturation idx=%0d got=%p want='{1,2,3,3,3}", i, cnt_log);
            end
        end
    endtask

    task automatic test_random();
        select_dut(1'b0);
        do_reset(2'b00, 6'd0, 8'd0, 8'd0);
        run_traffic(20, 1);
        select_dut(1'b1);
        do_reset(2'b00, 6'd0, 8'd0, 8'd0);
        run_traffic(10, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        select_dut(1'b0);
        model_reset();
        test_reset();
        test_single_request();
        test_simultaneous();
        test_contention();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_op();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_req_scheduler.md
Name: alu_req_scheduler

Overview:
- Shares one combinational ALU between two requesters. Arbitrates round-robin and issues each accepted op to the ALU with registered, stable operands.
- Waits a programmable settle time, captures o_result/o_status-equivalent data, and returns it with a requester tag over a valid/ready response channel.
- Sits between the control sequencers and the ALU instance in the datapath top.

Parameters:
- OP_W, 3, ALU opcode width.
- ARG_W, 4, width of each ALU argument (A, B).
- RES_W, 8, ALU result width.
- STAT_W, 4, ALU status flag width.
- SETTLE, 1, cycles the issued operands are held before capture (1..15).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- i_clk, input, 1, clock; all state updates on rising edge.
- i_reset, input, 1, asynchronous active-low reset.
- i_req_valid, input, 2, per-requester request valid.
- o_req_ready, output, 2, per-requester accept; one-hot or zero.
- i_req_op, input, 2*OP_W, opcodes; requester r occupies slice [r*OP_W +: OP_W].
- i_req_arg_A, input, 2*ARG_W, A operands, same packing.
- i_req_arg_B, input, 2*ARG_W, B operands, same packing.
- o_alu_op, output, OP_W, registered opcode to ALU.
- o_alu_arg_A, output, ARG_W, registered A to ALU.
- o_alu_arg_B, output, ARG_W, registered B to ALU.
- i_alu_result, input, RES_W, ALU result.
- i_alu_status, input, STAT_W, ALU status flags.
- o_rsp_valid, output, 1, response valid.
- i_rsp_ready, input, 1, response consumer ready.
- o_rsp_tag, output, 1, requester index of the response.
- o_rsp_result, output, RES_W, captured result.
- o_rsp_status, output, STAT_W, captured status.
- o_busy, output, 1, high in any state other than IDLE.
- o_op_count, output, CNT_W, completed responses; saturates at all-ones.

Behaviour:
- Reset (i_reset low, asynchronous):
  - FSM goes to IDLE.
  - All registered outputs are 0: o_alu_*, o_rsp_*, o_rsp_valid, o_op_count.
  - last_grant is set to 1, so requester 0 wins first. Settle counter is 0.
  - A reset mid-operation drops the in-flight op with no response; the requester re-presents it.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - o_req_ready is combinational: ready[g] = 1 only for the granted g.
  - Grant rule: if only one valid, grant it. If both valid, grant the one not equal to last_grant.
  - On valid&ready: latch op/A/B slices into o_alu_*, store tag = g, set last_grant = g, load settle counter = SETTLE-1, go to ISSUE.
  - With no request, o_alu_* hold their previous values.
- ISSUE: o_req_ready = 0. If counter == 0, go to CAPTURE; else decrement.
- CAPTURE (one cycle):
  - Register i_alu_result into o_rsp_result and i_alu_status into o_rsp_status.
  - o_rsp_tag = tag; o_rsp_valid <= 1; go to RESP.
- RESP:
  - Hold all o_rsp_* stable until i_rsp_ready.
  - On o_rsp_valid & i_rsp_ready: o_rsp_valid <= 0, increment o_op_count unless all-ones, go to IDLE.
- Latency, accept edge to o_rsp_valid high: SETTLE+1 cycles.
- Minimum initiation interval: SETTLE+3 cycles, achieved when i_rsp_ready is held high.
- ALU inputs change only on the accept edge. They are stable throughout ISSUE and CAPTURE.
- Requester valid must not depend on ready. A requester losing arbitration keeps valid high and is served in the next IDLE.
- Back-to-back from the same requester while the other is idle: granted every time.
- No combinational path from i_alu_* or i_rsp_ready to o_req_ready.
- Widths: result/status are captured verbatim; no extension or truncation here.

Test Plan:
- Reset then single request: req0 op=000, A=9, B=2, SETTLE=1; ALU model returns result=5, status=0000.
  -> ready[0] pulses the first cycle; o_rsp_valid rises 2 cycles after accept with tag=0, result=0x05, status=0000; o_op_count=1 after handshake.
- Simultaneous requests right after reset: req0 (A=3, B=1) and req1 (A=7, B=2) both valid.
  -> req0 served first, then req1. Tags 0, 1 in order. Second accept occurs 1 cycle after the first response handshake.
- Persistent contention for 6 ops: both valid continuously.
  -> Grants alternate 0,1,0,1,0,1. o_op_count=6. No requester starved.
- Backpressure: i_rsp_ready low for 5 cycles during RESP.
  -> o_rsp_valid, tag, result and status constant. No new o_req_ready. o_alu_* unchanged.
- Reset mid-op: assert i_reset low during ISSUE with SETTLE=4.
  -> All outputs 0 immediately. After release, FSM is in IDLE and o_op_count=0. A re-presented request completes normally.
- Counter saturation (CNT_W=2): 5 completed ops.
  -> o_op_count reads 1, 2, 3, 3, 3.
